sha256_nonce_scheduler: RTL

//  Sequences a nonce sweep across N_CORES parallel SHA-256 double-hash cores for bitcoin_hash.

---
 rtl/bitcoin_pkg.sv | 18 +
 rtl/sha256_nonce_scheduler_rr_arbiter.sv | 51 +++++
 rtl/sha256_nonce_scheduler.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/bitcoin_pkg.sv
// Shared types for the SHA-256 nonce scheduler: FSM/core states and digest layout.
package bitcoin_pkg;

  typedef enum logic [0:0] {StIdle, StRun} sched_state_e;

  typedef enum logic [1:0] {CoreFree, CoreBusy, CoreHeld} core_stat_e;

  localparam int unsigned WORDS_PER_DIGEST = 8;

  // Element [7] holds h0 (bits [255:224]) and element [0] holds h7.
  typedef logic [WORDS_PER_DIGEST-1:0][31:0] digest_t;

  // Return digest word h_k.
  function automatic logic [31:0] digest_word(input digest_t d, input logic [2:0] k);
    return d[3'd7 - k];
  endfunction

endpackage

// File: rtl/sha256_nonce_scheduler_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after the pointer; the pointer
// moves to one past the granted index when advance is asserted.
module rr_arbiter #(
  parameter int unsigned N = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] grant,
  output logic         grant_valid
);

  localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1;

  logic [IdxW-1:0] ptr_q, ptr_d;
  logic [IdxW-1:0] gidx;
  logic [IdxW-1:0] idx;

  // Search requesters starting at the pointer and compute the next pointer.
  always_comb begin
    grant       = '0;
    grant_valid = 1'b0;
    gidx        = '0;
    idx         = '0;
    for (int unsigned off = 0; off < N; off++) begin
      idx = IdxW'((32'(ptr_q) + off) % N);
      if (!grant_valid && req[idx]) begin
        grant_valid = 1'b1;
        gidx        = idx;
      end
    end
    if (grant_valid) begin
      grant[gidx] = 1'b1;
    end
    ptr_d = ptr_q;
    if (advance && grant_valid) begin
      ptr_d = (gidx == IdxW'(N - 1)) ? '0 : gidx + IdxW'(1);
    end
  end

  // Pointer register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/sha256_nonce_scheduler.sv
// Nonce sweep scheduler: launches nonces on free hash cores, latches returned digests and
// writes each digest as 8 words at output_addr + 8*nonce + k through one write port.
module sha256_nonce_scheduler
  import bitcoin_pkg::*;
#(
  parameter int unsigned N_CORES    = 4,
  parameter int unsigned NUM_NONCES = 16,
  parameter int unsigned NONCE_W    = 32
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            start,
  input  logic [15:0]                     output_addr,
  output logic                            done,
  output logic [N_CORES-1:0]              core_start,
  output logic [N_CORES-1:0][NONCE_W-1:0] core_nonce,
  input  logic [N_CORES-1:0]              core_done,
  input  logic [N_CORES-1:0][255:0]       core_hash,
  output logic                            mem_we,
  output logic [15:0]                     mem_addr,
  output logic [31:0]                     mem_write_data,
  output logic                            protocol_err
);

  localparam int unsigned CoreW = (N_CORES > 1) ? $clog2(N_CORES) : 1;
  localparam logic [NONCE_W-1:0] NumNonces = NONCE_W'(NUM_NONCES);

  sched_state_e       state_q, state_d;
  logic [15:0]        base_q, base_d;
  logic [NONCE_W-1:0] next_nonce_q, next_nonce_d;
  core_stat_e         stat_q [N_CORES];
  core_stat_e         stat_d [N_CORES];
  logic [NONCE_W-1:0] nonce_q [N_CORES];
  logic [NONCE_W-1:0] nonce_d [N_CORES];
  digest_t            dig_q [N_CORES];
  digest_t            dig_d [N_CORES];
  logic               wr_busy_q, wr_busy_d;
  logic [CoreW-1:0]   wr_core_q, wr_core_d;
  logic [2:0]         wr_cnt_q, wr_cnt_d;
  logic               perr_q, perr_d;

  logic [N_CORES-1:0] held, grant;
  logic               grant_valid, advance;
  logic [CoreW-1:0]   grant_idx, launch_idx, wr_sel;
  logic               launch_found, any_active;
  logic [2:0]         wr_k;

  rr_arbiter #(.N(N_CORES)) u_arb (
    .clk        (clk),
    .reset_n    (reset_n),
    .req        (held),
    .advance    (advance),
    .grant      (grant),
    .grant_valid(grant_valid)
  );

  // Core status summary and one-hot grant decode.
  always_comb begin
    held       = '0;
    grant_idx  = '0;
    any_active = 1'b0;
    for (int unsigned i = 0; i < N_CORES; i++) begin
      held[i] = (stat_q[i] == CoreHeld);
      if (stat_q[i] != CoreFree) any_active = 1'b1;
      if (grant[i]) grant_idx = CoreW'(i);
    end
  end

  // Sweep FSM, dispatch, digest capture and write-back sequencing.
  always_comb begin
    state_d        = state_q;
    base_d         = base_q;
    next_nonce_d   = next_nonce_q;
    stat_d         = stat_q;
    nonce_d        = nonce_q;
    dig_d          = dig_q;
    wr_busy_d      = wr_busy_q;
    wr_core_d      = wr_core_q;
    wr_cnt_d       = wr_cnt_q;
    perr_d         = perr_q;
    core_start     = '0;
    advance        = 1'b0;
    mem_we         = 1'b0;
    mem_addr       = '0;
    mem_write_data = '0;
    launch_found   = 1'b0;
    launch_idx     = '0;
    wr_sel         = wr_core_q;
    wr_k           = wr_cnt_q;
    for (int unsigned i = 0; i < N_CORES; i++) begin
      core_nonce[i] = nonce_q[i];
    end

    // A done pulse is only meaningful from a busy core; anything else is flagged and dropped.
    for (int unsigned i = 0; i < N_CORES; i++) begin
      if (core_done[i]) begin
        if (stat_q[i] == CoreBusy) begin
          stat_d[i] = CoreHeld;
          dig_d[i]  = core_hash[i];
        end else begin
          perr_d = 1'b1;
        end
      end
    end

    unique case (state_q)
      StIdle: begin
        base_d       = output_addr;
        next_nonce_d = '0;
        if (start) begin
          state_d = StRun;
          perr_d  = 1'b0;
        end
      end
      StRun: begin
        for (int unsigned i = 0; i < N_CORES; i++) begin
          if (!launch_found && stat_q[i] == CoreFree) begin
            launch_found = 1'b1;
            launch_idx   = CoreW'(i);
          end
        end
        if (launch_found && next_nonce_q < NumNonces) begin
          core_start[launch_idx] = 1'b1;
          core_nonce[launch_idx] = next_nonce_q;
          nonce_d[launch_idx]    = next_nonce_q;
          stat_d[launch_idx]     = CoreBusy;
          next_nonce_d           = next_nonce_q + NONCE_W'(1);
        end

        // Word 0 goes out in the grant cycle itself, so back-to-back digests stay contiguous.
        if (wr_busy_q || grant_valid) begin
          wr_sel         = wr_busy_q ? wr_core_q : grant_idx;
          wr_k           = wr_busy_q ? wr_cnt_q : 3'd0;
          advance        = !wr_busy_q;
          mem_we         = 1'b1;
          mem_addr       = base_q + 16'(nonce_q[wr_sel] << 3) + 16'(wr_k);
          mem_write_data = digest_word(dig_q[wr_sel], wr_k);
          if (wr_k == 3'd7) begin
            wr_busy_d      = 1'b0;
            wr_cnt_d       = '0;
            stat_d[wr_sel] = CoreFree;
          end else begin
            wr_busy_d = 1'b1;
            wr_core_d = wr_sel;
            wr_cnt_d  = wr_k + 3'd1;
          end
        end

        if (next_nonce_q == NumNonces && !any_active && !wr_busy_q) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers; reset aborts any sweep in progress.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      base_q       <= '0;
      next_nonce_q <= '0;
      wr_busy_q    <= 1'b0;
      wr_core_q    <= '0;
      wr_cnt_q     <= '0;
      perr_q       <= 1'b0;
      for (int unsigned i = 0; i < N_CORES; i++) begin
        stat_q[i]  <= CoreFree;
        nonce_q[i] <= '0;
        dig_q[i]   <= '0;
      end
    end else begin
      state_q      <= state_d;
      base_q       <= base_d;
      next_nonce_q <= next_nonce_d;
      wr_busy_q    <= wr_busy_d;
      wr_core_q    <= wr_core_d;
      wr_cnt_q     <= wr_cnt_d;
      perr_q       <= perr_d;
      stat_q       <= stat_d;
      nonce_q      <= nonce_d;
      dig_q        <= dig_d;
    end
  end

  assign done         = (state_q == StIdle);
  assign protocol_err = perr_q;

endmodule
